// File: rtl/s_axil_register_slave_if.sv
// AXI4-Lite bus bundle between a register master and s_axil_register_slave.
// Carries the five AXI4-Lite channels:
//   AW: AWADDR, AWVALID, AWREADY
//   W : WDATA, WSTRB, WVALID, WREADY
//   B : BRESP, BVALID, BREADY
//   AR: ARADDR, ARVALID, ARREADY
//   R : RDATA, RRESP, RVALID, RREADY
// master modport drives addresses, data, valids and response readies;
// slave modport drives address/data readies and the responses.
interface s_axil_register_slave_if #(
    parameter int S_AXI_DATA_WIDTH = 32,
    parameter int S_AXI_ADDR_WIDTH = 32
);
    logic [S_AXI_ADDR_WIDTH-1:0]   AWADDR;
    logic                          AWVALID;
    logic                          AWREADY;
    logic [S_AXI_DATA_WIDTH-1:0]   WDATA;
    logic [S_AXI_DATA_WIDTH/8-1:0] WSTRB;
    logic                          WVALID;
    logic                          WREADY;
    logic [1:0]                    BRESP;
    logic                          BVALID;
    logic                          BREADY;
    logic [S_AXI_ADDR_WIDTH-1:0]   ARADDR;
    logic                          ARVALID;
    logic                          ARREADY;
    logic [S_AXI_DATA_WIDTH-1:0]   RDATA;
    logic [1:0]                    RRESP;
    logic                          RVALID;
    logic                          RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/s_axil_register_slave.sv
// AXI4-Lite slave register file of NUM_REG words, S_AXI_DATA_WIDTH bits each.
// AW and W are accepted independently in either order; the write commits on
// the first edge where both are available, honouring byte strobes. Reads
// return one cycle after the AR handshake. Out-of-range accesses answer SLVERR.
// Ports:
//   ACLK    - clock, rising edge
//   ARESET  - synchronous active-high reset
//   s_axil  - AXI4-Lite slave bus (AW/W/B/AR/R channels)
//   REG_OUT - all registers flattened; reg k at [k*S_AXI_DATA_WIDTH +: S_AXI_DATA_WIDTH]
module s_axil_register_slave #(
    parameter int S_AXI_DATA_WIDTH = 32,
    parameter int S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REG          = 16
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    s_axil_register_slave_if.slave              s_axil,
    output logic [NUM_REG*S_AXI_DATA_WIDTH-1:0] REG_OUT
);

    localparam int DATA_W = S_AXI_DATA_WIDTH;
    localparam int ADDR_W = S_AXI_ADDR_WIDTH;
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(NUM_REG);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REG * 4);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [DATA_W-1:0] apply_strobes(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] merged;
        merged = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) merged[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return merged;
    endfunction

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_LIMIT;
    endfunction

    logic [DATA_W-1:0] regs [NUM_REG];

    logic              aw_held;
    logic              w_held;
    logic [ADDR_W-1:0] aw_addr_held;
    logic [DATA_W-1:0] w_data_held;
    logic [STRB_W-1:0] w_strb_held;

    logic              bvalid;
    logic [1:0]        bresp;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_in_range;
    logic              rd_in_range;

    assign s_axil.AWREADY = !ARESET && !aw_held && !bvalid;
    assign s_axil.WREADY  = !ARESET && !w_held && !bvalid;
    assign s_axil.ARREADY = !ARESET && !rvalid;
    assign s_axil.BVALID  = bvalid;
    assign s_axil.BRESP   = bresp;
    assign s_axil.RVALID  = rvalid;
    assign s_axil.RDATA   = rdata;
    assign s_axil.RRESP   = rresp;

    assign aw_hs = s_axil.AWVALID && s_axil.AWREADY;
    assign w_hs  = s_axil.WVALID && s_axil.WREADY;
    assign ar_hs = s_axil.ARVALID && s_axil.ARREADY;

    // A channel counts as present if it was held earlier or handshakes now;
    // the commit edge is the first one with both present.
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_addr = aw_held ? aw_addr_held : s_axil.AWADDR;
    assign wr_data = w_held ? w_data_held : s_axil.WDATA;
    assign wr_strb = w_held ? w_strb_held : s_axil.WSTRB;

    assign wr_idx      = wr_addr[IDX_W+1:2];
    assign rd_idx      = s_axil.ARADDR[IDX_W+1:2];
    assign wr_in_range = addr_in_range(wr_addr);
    assign rd_in_range = addr_in_range(s_axil.ARADDR);

    // Control state, register file and responses
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REG; k++) regs[k] <= '0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            // Write channel: commit cannot coincide with a pending B because
            // neither AW nor W is accepted while BVALID is high.
            if (commit) begin
                if (wr_in_range) begin
                    regs[wr_idx] <= apply_strobes(regs[wr_idx], wr_data, wr_strb);
                end
                bresp   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                bvalid  <= 1'b1;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
                if (bvalid && s_axil.BREADY) bvalid <= 1'b0;
            end

            // Read channel: regs sampled before this edge's write lands
            if (ar_hs) begin
                rdata  <= rd_in_range ? regs[rd_idx] : '0;
                rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                rvalid <= 1'b1;
            end else if (rvalid && s_axil.RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    // Held AW/W payloads; only meaningful while the matching flag is set
    always_ff @(posedge ACLK) begin
        if (aw_hs) aw_addr_held <= s_axil.AWADDR;
        if (w_hs) begin
            w_data_held <= s_axil.WDATA;
            w_strb_held <= s_axil.WSTRB;
        end
    end

    for (genvar k = 0; k < NUM_REG; k++) begin : g_reg_out
        assign REG_OUT[k*DATA_W +: DATA_W] = regs[k];
    end

endmodule

// File: tb/tb_s_axil_register_slave.sv
// Directed bench for s_axil_register_slave (32-bit data/address, 16 registers).
module tb_s_axil_register_slave;

    logic         clk;
    logic         rst;
    logic [511:0] reg_out;

    int checks = 0;
    int errors = 0;

    s_axil_register_slave_if #(.S_AXI_DATA_WIDTH(32), .S_AXI_ADDR_WIDTH(32)) bus ();

    s_axil_register_slave #(
        .S_AXI_DATA_WIDTH(32),
        .S_AXI_ADDR_WIDTH(32),
        .NUM_REG(16)
    ) dut (
        .ACLK(clk),
        .ARESET(rst),
        .s_axil(bus),
        .REG_OUT(reg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_at(input int k);
        return reg_out[k*32 +: 32];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int bdelay,
                             output logic [1:0] resp);
        logic hs_aw, hs_w;
        logic [1:0] resp0;
        int n;
        bus.AWADDR = addr; bus.AWVALID = 1'b1;
        bus.WDATA = data; bus.WSTRB = strb; bus.WVALID = 1'b1;
        bus.BREADY = 1'b0;
        n = 0;
        while ((bus.AWVALID || bus.WVALID) && n < 50) begin
            hs_aw = bus.AWVALID && bus.AWREADY;
            hs_w  = bus.WVALID && bus.WREADY;
            step();
            if (hs_aw) bus.AWVALID = 1'b0;
            if (hs_w)  bus.WVALID  = 1'b0;
            n++;
        end
        check("wr_accept", {bus.AWVALID, bus.WVALID}, 0);
        check("bvalid_rise", bus.BVALID, 1);
        resp0 = bus.BRESP;
        for (int i = 0; i < bdelay; i++) begin
            check("bp_bvalid", bus.BVALID, 1);
            check("bp_bresp", bus.BRESP, resp0);
            check("bp_awready", bus.AWREADY, 0);
            check("bp_wready", bus.WREADY, 0);
            step();
        end
        resp = bus.BRESP;
        bus.BREADY = 1'b1;
        step();
        bus.BREADY = 1'b0;
        check("bvalid_clear", bus.BVALID, 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rdelay,
                            output logic [31:0] data, output logic [1:0] resp);
        logic hs;
        logic [31:0] data0;
        int n;
        bus.ARADDR = addr; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
        n = 0;
        while (bus.ARVALID && n < 50) begin
            hs = bus.ARREADY;
            step();
            if (hs) bus.ARVALID = 1'b0;
            n++;
        end
        check("ar_accept", bus.ARVALID, 0);
        check("rvalid_rise", bus.RVALID, 1);
        data0 = bus.RDATA;
        for (int i = 0; i < rdelay; i++) begin
            check("bp_rvalid", bus.RVALID, 1);
            check("bp_rdata", bus.RDATA, data0);
            check("bp_arready", bus.ARREADY, 0);
            step();
        end
        data = bus.RDATA;
        resp = bus.RRESP;
        bus.RREADY = 1'b1;
        step();
        bus.RREADY = 1'b0;
        check("rvalid_clear", bus.RVALID, 0);
    endtask

    initial begin
        logic [1:0]   resp;
        logic [31:0]  rd;
        logic [511:0] snap;

        rst = 1'b1;
        bus.AWADDR = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

        // Reset state
        repeat (3) step();
        check("rst_awready", bus.AWREADY, 0);
        check("rst_wready", bus.WREADY, 0);
        check("rst_arready", bus.ARREADY, 0);
        check("rst_bvalid", bus.BVALID, 0);
        check("rst_rvalid", bus.RVALID, 0);
        check("rst_rdata", bus.RDATA, 0);
        check("rst_reg_out_lo", reg_out[63:0], 0);
        check("rst_reg_out_hi", reg_out[511:448], 0);
        rst = 1'b0;
        #1;
        check("idle_awready", bus.AWREADY, 1);
        check("idle_wready", bus.WREADY, 1);
        check("idle_arready", bus.ARREADY, 1);

        // Sequential write then read back
        for (int k = 0; k < 16; k++) begin
            axi_write(32'(k * 4), 32'(k + 1), 4'hF, 0, resp);
            check("seq_bresp", resp, 2'b00);
        end
        for (int k = 0; k < 16; k++) begin
            axi_read(32'(k * 4), 0, rd, resp);
            check("seq_rdata", rd, 32'(k + 1));
            check("seq_rresp", resp, 2'b00);
            check("seq_reg_out", reg_at(k), 32'(k + 1));
        end

        // W arrives 5 cycles ahead of AW
        bus.WDATA = 32'hDEADBEEF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        check("wfirst_wready", bus.WREADY, 1);
        step();
        bus.WVALID = 1'b0;
        check("wfirst_w_held", bus.WREADY, 0);
        repeat (4) begin
            check("wfirst_no_b", bus.BVALID, 0);
            step();
        end
        bus.AWADDR = 32'h08; bus.AWVALID = 1'b1;
        check("wfirst_awready", bus.AWREADY, 1);
        step();
        bus.AWVALID = 1'b0;
        check("wfirst_bvalid", bus.BVALID, 1);
        check("wfirst_bresp", bus.BRESP, 2'b00);
        check("wfirst_reg2", reg_at(2), 32'hDEADBEEF);
        bus.BREADY = 1'b1;
        step();
        bus.BREADY = 1'b0;
        check("wfirst_bclear", bus.BVALID, 0);

        // Byte strobes: lanes 0 and 2 only
        axi_write(32'h0C, 32'h11223344, 4'hF, 0, resp);
        axi_write(32'h0C, 32'hAABBCCDD, 4'b0101, 0, resp);
        check("strb_bresp", resp, 2'b00);
        axi_read(32'h0C, 0, rd, resp);
        check("strb_rdata", rd, 32'h11BB33DD);

        // Out of range
        snap = reg_out;
        axi_write(32'h40, 32'h12345678, 4'hF, 0, resp);
        check("oor_bresp", resp, 2'b10);
        check("oor_no_change_lo", reg_out[255:0], snap[255:0]);
        check("oor_no_change_hi", reg_out[511:256], snap[511:256]);
        axi_read(32'h7C, 0, rd, resp);
        check("oor_rresp", resp, 2'b10);
        check("oor_rdata", rd, 0);

        // Backpressure on B and R
        axi_write(32'h10, 32'h12345678, 4'hF, 10, resp);
        check("bp_final_bresp", resp, 2'b00);
        axi_read(32'h10, 10, rd, resp);
        check("bp_final_rdata", rd, 32'h12345678);
        check("bp_final_rresp", resp, 2'b00);

        // Read and commit to 0x20 on the same edge (reg8 holds 9)
        bus.AWADDR = 32'h20; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h55; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        bus.ARADDR = 32'h20; bus.ARVALID = 1'b1;
        step();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        check("conc_rvalid", bus.RVALID, 1);
        check("conc_rdata_old", bus.RDATA, 32'h9);
        check("conc_bvalid", bus.BVALID, 1);
        check("conc_reg8", reg_at(8), 32'h55);
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        step();
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        axi_read(32'h20, 0, rd, resp);
        check("conc_rdata_new", rd, 32'h55);

        // Reset with B and R pending
        bus.AWADDR = 32'h14; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h77; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        bus.ARADDR = 32'h14; bus.ARVALID = 1'b1;
        step();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
        check("pre_rst_bvalid", bus.BVALID, 1);
        check("pre_rst_rdata", bus.RDATA, 32'h6);
        rst = 1'b1;
        step();
        check("mid_rst_bvalid", bus.BVALID, 0);
        check("mid_rst_rvalid", bus.RVALID, 0);
        check("mid_rst_rdata", bus.RDATA, 0);
        check("mid_rst_bresp", bus.BRESP, 0);
        check("mid_rst_rresp", bus.RRESP, 0);
        check("mid_rst_awready", bus.AWREADY, 0);
        check("mid_rst_reg_out_lo", reg_out[255:0], 0);
        check("mid_rst_reg_out_hi", reg_out[511:256], 0);
        rst = 1'b0;

        // Reset discards a held AW
        bus.AWADDR = 32'h18; bus.AWVALID = 1'b1;
        step();
        bus.AWVALID = 1'b0;
        check("held_aw_awready", bus.AWREADY, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.WDATA = 32'hCAFE; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        step();
        bus.WVALID = 1'b0;
        check("discard_no_b", bus.BVALID, 0);
        check("discard_reg6", reg_at(6), 0);
        bus.AWADDR = 32'h18; bus.AWVALID = 1'b1;
        step();
        bus.AWVALID = 1'b0;
        check("after_rst_bvalid", bus.BVALID, 1);
        check("after_rst_reg6", reg_at(6), 32'hCAFE);
        bus.BREADY = 1'b1;
        step();
        bus.BREADY = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
